// File: rtl/mem_wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_wb_stage
// Purpose  : Memory-access stage plus MEM/WB pipeline register of the 5-stage
//            core. Performs the data-memory load/store for the instruction in
//            EXE/MEM and presents the register-file writeback port one cycle
//            later. Supports pipeline stall (hold) and flush (bubble).
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   rising-edge clock for all state
//   rst          in   asynchronous active-high reset
//   stall        in   hold all stage state, suppress memory write
//   flush        in   load a bubble into MEM/WB, suppress memory write
//   wen_in       in   register-write enable from EXE/MEM
//   alu_in       in   ALU result / memory address from EXE/MEM
//   waddr_in     in   destination register from EXE/MEM
//   rdata2_in    in   store data from EXE/MEM
//   memRead_in   in   load request
//   memWrite_in  in   store request
//   memtoReg_in  in   select load data for writeback
//   wb_wen       out  register-file write enable
//   wb_waddr     out  register-file write address
//   wb_wdata     out  register-file write data
//   wb_memtoReg  out  registered memtoReg (for forwarding)
//   wb_alu       out  registered ALU result
// ============================================================================
module mem_wb_stage #(
  parameter int DSIZE  = 16,
  parameter int ASIZE  = 4,
  parameter int MEM_AW = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic             wen_in,
  input  logic [DSIZE-1:0] alu_in,
  input  logic [ASIZE-1:0] waddr_in,
  input  logic [DSIZE-1:0] rdata2_in,
  input  logic             memRead_in,
  input  logic             memWrite_in,
  input  logic             memtoReg_in,
  output logic             wb_wen,
  output logic [ASIZE-1:0] wb_waddr,
  output logic [DSIZE-1:0] wb_wdata,
  output logic             wb_memtoReg,
  output logic [DSIZE-1:0] wb_alu
);

  localparam int DEPTH = 1 << MEM_AW;

  logic [DSIZE-1:0]  mem [DEPTH];
  logic [DSIZE-1:0]  mem_q;
  logic [MEM_AW-1:0] mem_addr;
  logic              mem_we;
  logic              mem_re;

  // Upper ALU bits are ignored, so addresses wrap modulo the memory depth.
  assign mem_addr = alu_in[MEM_AW-1:0];

  // Writes are blocked during reset as well as stall/flush; reset never
  // clears the array, so contents persist across it.
  assign mem_we = memWrite_in & ~stall & ~flush & ~rst;
  assign mem_re = memRead_in  & ~stall & ~flush;

  // Data memory: no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= rdata2_in;
    end
  end

  // Load register. Non-blocking capture gives read-first behaviour: a
  // same-edge store to the same address returns the old word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '0;
    end else if (mem_re) begin
      mem_q <= mem[mem_addr];
    end
  end

  // MEM/WB pipeline register: flush wins over stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_wen      <= 1'b0;
      wb_waddr    <= '0;
      wb_alu      <= '0;
      wb_memtoReg <= 1'b0;
    end else if (flush) begin
      wb_wen      <= 1'b0;
      wb_waddr    <= '0;
      wb_alu      <= '0;
      wb_memtoReg <= 1'b0;
    end else if (!stall) begin
      wb_wen      <= wen_in;
      wb_waddr    <= waddr_in;
      wb_alu      <= alu_in;
      wb_memtoReg <= memtoReg_in;
    end
  end

  assign wb_wdata = wb_memtoReg ? mem_q : wb_alu;

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_wb_stage
// Purpose  : Self-checking bench for mem_wb_stage. A cycle-level model of the
//            stage is compared against the DUT on every falling edge, and
//            directed vectors carry hand-computed literal expectations.
// Revision : 1.0  initial release
// ============================================================================
module tb_mem_wb_stage;

  localparam int DSIZE  = 16;
  localparam int ASIZE  = 4;
  localparam int MEM_AW = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             stall = 1'b0;
  logic             flush = 1'b0;
  logic             wen_in = 1'b0;
  logic [DSIZE-1:0] alu_in = '0;
  logic [ASIZE-1:0] waddr_in = '0;
  logic [DSIZE-1:0] rdata2_in = '0;
  logic             memRead_in = 1'b0;
  logic             memWrite_in = 1'b0;
  logic             memtoReg_in = 1'b0;
  logic             wb_wen;
  logic [ASIZE-1:0] wb_waddr;
  logic [DSIZE-1:0] wb_wdata;
  logic             wb_memtoReg;
  logic [DSIZE-1:0] wb_alu;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  mem_wb_stage #(.DSIZE(DSIZE), .ASIZE(ASIZE), .MEM_AW(MEM_AW)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .wen_in(wen_in), .alu_in(alu_in), .waddr_in(waddr_in),
    .rdata2_in(rdata2_in), .memRead_in(memRead_in),
    .memWrite_in(memWrite_in), .memtoReg_in(memtoReg_in),
    .wb_wen(wb_wen), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .wb_memtoReg(wb_memtoReg), .wb_alu(wb_alu)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // Unwritten words stay X, so comparisons with !== tolerate them.
  logic [DSIZE-1:0] m_mem [1 << MEM_AW];
  logic [DSIZE-1:0] m_q   = '0;
  logic             m_wen = 1'b0;
  logic [ASIZE-1:0] m_waddr = '0;
  logic [DSIZE-1:0] m_alu = '0;
  logic             m_mt  = 1'b0;

  always @(posedge clk or posedge rst) begin
    int a;
    if (rst) begin
      m_q = '0; m_wen = 1'b0; m_waddr = '0; m_alu = '0; m_mt = 1'b0;
    end else if (flush) begin
      m_wen = 1'b0; m_waddr = '0; m_alu = '0; m_mt = 1'b0;
    end else if (!stall) begin
      a = int'(alu_in) % (1 << MEM_AW);
      if (memRead_in)  m_q = m_mem[a];         // old contents first
      if (memWrite_in) m_mem[a] = rdata2_in;
      m_wen = wen_in; m_waddr = waddr_in; m_alu = alu_in; m_mt = memtoReg_in;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    logic [DSIZE-1:0] exp_wdata;
    if (chk_en) begin
      exp_wdata = m_mt ? m_q : m_alu;
      n_tests++;
      if (wb_wen !== m_wen || wb_waddr !== m_waddr || wb_alu !== m_alu ||
          wb_memtoReg !== m_mt || wb_wdata !== exp_wdata) begin
        n_fail++;
        $display("FAIL model t=%0t got wen=%b waddr=%h alu=%h mt=%b wdata=%h exp wen=%b waddr=%h alu=%h mt=%b wdata=%h",
                 $time, wb_wen, wb_waddr, wb_alu, wb_memtoReg, wb_wdata,
                 m_wen, m_waddr, m_alu, m_mt, exp_wdata);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got %h exp %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic w, input logic [ASIZE-1:0] wa, input logic [DSIZE-1:0] alu,
                       input logic [DSIZE-1:0] d2, input logic mr, input logic mw,
                       input logic mt, input logic st, input logic fl);
    wen_in = w; waddr_in = wa; alu_in = alu; rdata2_in = d2;
    memRead_in = mr; memWrite_in = mw; memtoReg_in = mt; stall = st; flush = fl;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".wen"},   32'(wb_wen),      32'h0);
    chk({tag, ".waddr"}, 32'(wb_waddr),    32'h0);
    chk({tag, ".wdata"}, 32'(wb_wdata),    32'h0);
    chk({tag, ".alu"},   32'(wb_alu),      32'h0);
    chk({tag, ".mt"},    32'(wb_memtoReg), 32'h0);
  endtask

  // Pulse rst between edges and check outputs clear before the next edge.
  task automatic async_reset(input string tag);
    #2 rst = 1'b1;
    #1 chk_zero(tag);
    tick();
    rst = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    #1 rst = 1'b1;
    chk_en = 1'b1;
    tick(); tick();
    chk_zero("reset");
    rst = 1'b0;

    // ALU pass-through
    drive(1, 4'd5, 16'h1234, 16'h0, 0, 0, 0, 0, 0); tick();
    chk("pass.wen",   32'(wb_wen),   32'h1);
    chk("pass.waddr", 32'(wb_waddr), 32'h5);
    chk("pass.wdata", 32'(wb_wdata), 32'h1234);

    // Asynchronous reset while wb_wen=1
    async_reset("rst_mid");

    // Store then back-to-back load, then wrapped address
    drive(0, 4'd0, 16'h0010, 16'hBEEF, 0, 1, 0, 0, 0); tick();
    drive(1, 4'd3, 16'h0010, 16'h0, 1, 0, 1, 0, 0); tick();
    chk("load.wdata", 32'(wb_wdata), 32'hBEEF);
    chk("load.waddr", 32'(wb_waddr), 32'h3);
    drive(1, 4'd3, 16'h0110, 16'h0, 1, 0, 1, 0, 0); tick();
    chk("wrap.wdata", 32'(wb_wdata), 32'hBEEF);
    chk("wrap.alu",   32'(wb_alu),   32'h0110);

    // Preload words used later
    drive(0, 4'd0, 16'h0007, 16'h1111, 0, 1, 0, 0, 0); tick();
    drive(0, 4'd0, 16'h0009, 16'h0909, 0, 1, 0, 0, 0); tick();
    drive(0, 4'd0, 16'h0004, 16'h4444, 0, 1, 0, 0, 0); tick();

    // Read-first collision
    drive(1, 4'd6, 16'h0007, 16'h2222, 1, 1, 1, 0, 0); tick();
    chk("coll.old", 32'(wb_wdata), 32'h1111);
    drive(1, 4'd6, 16'h0007, 16'h0, 1, 0, 1, 0, 0); tick();
    chk("coll.new", 32'(wb_wdata), 32'h2222);

    // Stall for 3 cycles with a pending store to address 9
    drive(1, 4'd2, 16'h00AA, 16'h0, 0, 0, 0, 0, 0); tick();
    chk("stall.pre", 32'(wb_wdata), 32'h00AA);
    drive(1, 4'd7, 16'h0009, 16'hDEAD, 0, 1, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall.wdata", 32'(wb_wdata), 32'h00AA);
      chk("stall.waddr", 32'(wb_waddr), 32'h2);
    end
    drive(1, 4'd8, 16'h0055, 16'h0, 0, 0, 0, 0, 0); tick();
    chk("stall.rel",   32'(wb_wdata), 32'h0055);
    chk("stall.relwa", 32'(wb_waddr), 32'h8);
    drive(1, 4'd1, 16'h0009, 16'h0, 1, 0, 1, 0, 0); tick();
    chk("stall.mem9", 32'(wb_wdata), 32'h0909);

    // Flush with a pending store to address 4
    drive(1, 4'd5, 16'h0004, 16'hDEAD, 1, 1, 1, 0, 1); tick();
    chk("flush.wen",   32'(wb_wen),   32'h0);
    chk("flush.wdata", 32'(wb_wdata), 32'h0);
    chk("flush.waddr", 32'(wb_waddr), 32'h0);
    drive(1, 4'd1, 16'h0004, 16'h0, 1, 0, 1, 0, 0); tick();
    chk("flush.mem4", 32'(wb_wdata), 32'h4444);

    // Flush and stall together still insert a bubble
    drive(1, 4'd4, 16'h0077, 16'h0, 0, 0, 0, 0, 0); tick();
    chk("fs.pre", 32'(wb_wdata), 32'h0077);
    drive(1, 4'd4, 16'h0077, 16'h0, 0, 0, 0, 1, 1); tick();
    chk("fs.wen",   32'(wb_wen),   32'h0);
    chk("fs.wdata", 32'(wb_wdata), 32'h0);

    // Reset in the middle of a stall; memory survives
    drive(1, 4'd9, 16'h00CC, 16'h0, 0, 0, 0, 0, 0); tick();
    drive(1, 4'd9, 16'h00CC, 16'h0, 0, 0, 0, 1, 0); tick();
    async_reset("rst_stall");
    drive(1, 4'd3, 16'h0010, 16'h0, 1, 0, 1, 0, 0); tick();
    chk("persist.mem10", 32'(wb_wdata), 32'hBEEF);

    drive(0, 4'd0, 16'h0, 16'h0, 0, 0, 0, 0, 0); tick(); tick();
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_wb_stage.md
# mem_wb_stage

Memory-access stage plus MEM/WB pipeline register for the 5-stage core. Consumes the EXE/MEM register outputs (write enable, ALU result, destination address, store data, memRead/memWrite/memtoReg), performs the data-memory access, and presents the writeback port (enable, address, data) to the register file one cycle later. Contains the word-addressed data memory, and supports pipeline stall and flush (bubble insertion).

## Interface
- DSIZE, 16: datapath width, equal to `DSIZE.
- ASIZE, 4: register-file address width, equal to `ASIZE.
- MEM_AW, 8: data-memory word-address width (2^MEM_AW words of DSIZE bits).

- clk  in  1  single clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  hold all stage state; suppress memory write.
- flush  in  1  load a bubble into MEM/WB.
- wen_in  in  1  register-write enable from EXE/MEM.
- alu_in  in  DSIZE  ALU result / memory address from EXE/MEM.
- waddr_in  in  ASIZE  destination register from EXE/MEM.
- rdata2_in  in  DSIZE  store data from EXE/MEM.
- memRead_in, memWrite_in, memtoReg_in  in  1 each  control from EXE/MEM.
- wb_wen  out  1  register-file write enable.
- wb_waddr  out  ASIZE  register-file write address.
- wb_wdata  out  DSIZE  register-file write data.
- wb_memtoReg  out  1  registered memtoReg (for forwarding logic).
- wb_alu  out  DSIZE  registered ALU result.

## Operation
- Memory address = alu_in[MEM_AW-1:0]; upper bits ignored (address wraps modulo 2^MEM_AW).
- Store: on rising edge with memWrite_in=1, stall=0, flush=0, mem[addr] <= rdata2_in.
- Load: on rising edge with memRead_in=1 and stall=0, mem_q <= mem[addr]; read-first — a same-cycle write to the same address returns old contents.
- memRead_in=0 and stall=0: mem_q retains its value (no read toggling).
- MEM/WB register (wb_wen, wb_waddr, wb_alu, wb_memtoReg) captures wen_in, waddr_in, alu_in, memTo Reg_in each edge when stall=0, flush=0.
- wb_wdata combinational: wb_memtoReg ? mem_q : wb_alu.
- flush=1 (stall ignored): wb_wen <= 0, wb_memtoReg <= 0, wb_waddr <= 0, wb_alu <= 0; memory write suppressed; mem_q held.
- stall=1, flush=0: all registers and mem_q hold; no memory write.
- Priority: rst > flush > stall > normal.
- Memory array is not cleared by reset; contents persist across rst.
- waddr 0 writes are passed through unchanged; register-file enforces r0.

## Timing
- Reset (async, immediate): wb_wen=0, wb_waddr=0, wb_alu=0, wb_memtoReg=0, mem_q=0, hence wb_wdata=0.
- Reset deasserts synchronously-safe: first capture on first rising edge with rst=0.
- Latency: inputs at edge N -> wb_* valid after edge N (one cycle), including load data.
- Store visible to a load issued on the following edge (back-to-back store then load same address returns new data).
- Stall held k cycles: outputs frozen k cycles, then resume with inputs present at release edge.
- Reset mid-stall or mid-flush: outputs forced to reset values; memory untouched.

## Test plan
- Reset: assert rst mid-cycle with wb_wen=1 -> all outputs 0 immediately, before next edge.
- ALU pass-through: wen_in=1, waddr_in=5, alu_in=0x1234, memtoReg_in=0 -> after one edge wb_wen=1, wb_waddr=5, wb_wdata=0x1234.
- Store/load: store rdata2_in=0xBEEF at alu_in=0x0010, then load same address with memtoReg_in=1, waddr_in=3 -> next cycle wb_wdata=0xBEEF, wb_waddr=3; load alu_in=0x0110 (wraps to 0x10) -> 0xBEEF.
- Read-first collision: mem[7]=0x1111; same edge memWrite and memRead at 7 with rdata2_in=0x2222 -> mem_q=0x1111; following load -> 0x2222.
- Stall: pipeline holding 0x00AA result, stall=1 for 3 cycles with memWrite_in=1 at address 9 -> outputs frozen, mem[9] unchanged; release -> new inputs captured.
- Flush: flush=1 with wen_in=1, memWrite_in=1, address 4 -> wb_wen=0, wb_wdata=0, mem[4] unchanged; flush and stall together -> bubble inserted.
